// File: rtl/ins_encoder.sv
// Buffered MIPS field-to-word encoder: packs R/I/J fields, queues words in a FIFO, tags each with its program address.
// Optional field-misuse checking is built when INS_ENC_CHECK_EN is defined; otherwise enc_err is tied low.
module ins_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     restart,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               opcode,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               shamt,
  input  logic [5:0]               funct,
  input  logic [15:0]              imm,
  input  logic [25:0]              address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              instruction,
  output logic [31:0]              p_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     enc_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  function automatic logic [31:0] encode(
    input logic [5:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
    input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn,
    input logic [15:0] f_imm, input logic [25:0] f_addr);
    logic [31:0] w;
    case (op)
      6'h00:        w = {op, f_rs, f_rt, f_rd, f_sh, f_fn};
      6'h02, 6'h03: w = {op, f_addr};
      default:      w = {op, f_rs, f_rt, f_imm};
    endcase
    return w;
  endfunction

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [31:0]   p_count_r;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   enc_word_s;

  assign enc_word_s  = encode(opcode, rs, rt, rd, shamt, funct, imm, address);
  assign in_ready    = (level_r != FULL_LVL) && !restart;
  assign out_valid   = (level_r != {(AW+1){1'b0}});
  assign instruction = out_valid ? mem_r[rd_ptr_r] : 32'h0000_0000;
  assign push_s      = in_valid && in_ready;
  // restart already blocks push via in_ready; pop must be blocked explicitly
  assign pop_s       = out_valid && out_ready && !restart;
  assign p_count     = p_count_r;
  assign level       = level_r;

  // FIFO storage; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= enc_word_s;
    end
  end

  // Pointers, occupancy and program address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      level_r   <= {(AW+1){1'b0}};
      p_count_r <= BASE_ADDR;
    end else if (restart) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      level_r   <= {(AW+1){1'b0}};
      p_count_r <= BASE_ADDR;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        p_count_r <= p_count_r + 32'd4;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

`ifdef INS_ENC_CHECK_EN
  function automatic logic misuse(
    input logic [5:0] op, input logic [4:0] f_rs, input logic [4:0] f_rt,
    input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn,
    input logic [15:0] f_imm, input logic [25:0] f_addr);
    logic bad;
    case (op)
      6'h00:        bad = (f_imm != 16'h0) || (f_addr != 26'h0);
      6'h02, 6'h03: bad = (f_rs != 5'h0) || (f_rt != 5'h0) || (f_rd != 5'h0) ||
                          (f_sh != 5'h0) || (f_fn != 6'h0) || (f_imm != 16'h0);
      default:      bad = (f_rd != 5'h0) || (f_sh != 5'h0) || (f_fn != 6'h0) ||
                          (f_addr != 26'h0);
    endcase
    return bad;
  endfunction

  logic enc_err_r;

  // Sticky misuse flag, cleared only by reset or restart
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_err_r <= 1'b0;
    end else if (restart) begin
      enc_err_r <= 1'b0;
    end else if (push_s && misuse(opcode, rs, rt, rd, shamt, funct, imm, address)) begin
      enc_err_r <= 1'b1;
    end else begin
      enc_err_r <= enc_err_r;
    end
  end

  assign enc_err = enc_err_r;
`else
  assign enc_err = 1'b0;
`endif

endmodule

// File: tb/tb_ins_encoder.sv
// Bench for ins_encoder: queue-based reference model checked every cycle plus directed literal checks.
module tb_ins_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef INS_ENC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = 6'h0;
  logic [4:0]  rs = 5'h0, rt = 5'h0, rd = 5'h0, shamt = 5'h0;
  logic [5:0]  funct = 6'h0;
  logic [15:0] imm = 16'h0;
  logic [25:0] address = 26'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] p_count;
  logic [2:0]  level;
  logic        enc_err;

  int n_vec  = 0;
  int n_fail = 0;

  ins_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .address(address),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .p_count(p_count), .level(level), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word layout by bit weights, FIFO as a queue
  function automatic logic [31:0] model_word(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
      input logic [4:0] c, input logic [4:0] s, input logic [5:0] f, input logic [15:0] i, input logic [25:0] t);
    logic [31:0] w;
    w = 32'(op) * 32'h0400_0000;
    if (op == 6'd0)
      w = w + 32'(a) * 32'h0020_0000 + 32'(b) * 32'h0001_0000 + 32'(c) * 32'h0000_0800 + 32'(s) * 32'h40 + 32'(f);
    else if (op == 6'd2 || op == 6'd3)
      w = w + 32'(t);
    else
      w = w + 32'(a) * 32'h0020_0000 + 32'(b) * 32'h0001_0000 + 32'(i);
    return w;
  endfunction

  function automatic bit model_bad(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
      input logic [4:0] c, input logic [4:0] s, input logic [5:0] f, input logic [15:0] i, input logic [25:0] t);
    if (op == 6'd0) return (i | 16'(t)) != 0 || t != 0;
    if (op == 6'd2 || op == 6'd3) return (a | b | c | s) != 0 || f != 0 || i != 0;
    return (c | s) != 0 || f != 0 || t != 0;
  endfunction

  logic [31:0] q[$];
  logic [31:0] m_pc  = BASE;
  logic        m_err = 1'b0;

  // Model update on each clock edge, cleared immediately by reset
  always @(posedge clk or negedge reset_n) begin
    bit do_push, do_pop;
    if (!reset_n) begin
      q.delete();
      m_pc  <= BASE;
      m_err <= 1'b0;
    end else if (restart) begin
      q.delete();
      m_pc  <= BASE;
      m_err <= 1'b0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) begin
        void'(q.pop_front());
        m_pc <= m_pc + 32'd4;
      end
      if (do_push) begin
        q.push_back(model_word(opcode, rs, rt, rd, shamt, funct, imm, address));
        if (CHK && model_bad(opcode, rs, rt, rd, shamt, funct, imm, address)) m_err <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("in_ready",    32'(in_ready),  32'((q.size() != DEPTH) && !restart));
    chk("out_valid",   32'(out_valid), 32'(q.size() != 0));
    chk("instruction", instruction,    (q.size() != 0) ? q[0] : 32'h0);
    chk("p_count",     p_count,        m_pc);
    chk("level",       32'(level),     32'(q.size()));
    chk("enc_err",     32'(enc_err),   32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_fields();
    opcode = 6'h0; rs = 5'h0; rt = 5'h0; rd = 5'h0; shamt = 5'h0;
    funct = 6'h0; imm = 16'h0; address = 26'h0;
  endtask

  task automatic offer_i(input logic [15:0] v);
    clear_fields();
    opcode = 6'd8; imm = v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #12;
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc", p_count, BASE);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_err", 32'(enc_err), 32'd0);

    // R-type add $8,$9,$10
    out_ready = 1'b1;
    opcode = 6'd0; rs = 5'd9; rt = 5'd10; rd = 5'd8; shamt = 5'd0; funct = 6'h20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clear_fields();
    chk("r_word", instruction, 32'h012A4020);
    chk("r_pc", p_count, 32'h0);
    chk("r_valid", 32'(out_valid), 32'd1);
    tick();
    chk("r_gone", 32'(out_valid), 32'd0);
    chk("r_pc_next", p_count, 32'h4);

    // J-type
    opcode = 6'd2; address = 26'h0100000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clear_fields();
    chk("j_word", instruction, 32'h08100000);
    tick();

    // I-type addi $8,$9,-1, then with a stray rd
    opcode = 6'd8; rs = 5'd9; rt = 5'd8; imm = 16'hFFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("i_word", instruction, 32'h2128FFFF);
    chk("i_err_clean", 32'(enc_err), 32'd0);
    tick();
    rd = 5'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clear_fields();
    chk("i_word_rd", instruction, 32'h2128FFFF);
    chk("i_err_rd", 32'(enc_err), 32'(CHK));
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_err", 32'(enc_err), 32'd0);
    chk("rs_pc", p_count, BASE);

    // Fill, refuse a fifth tuple, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer_i(16'(i));
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    offer_i(16'h0063);
    chk("full_refuse", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_word", instruction, 32'h2000_0000 + 32'(i));
      chk("drain_pc", p_count, BASE + 32'(4 * i));
      tick();
    end
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);

    // Full with pop in the same cycle still refuses the push
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer_i(16'h0010 + 16'(i));
    out_ready = 1'b1;
    offer_i(16'h0077);
    chk("fullpop_level", 32'(level), 32'd3);
    tick(); tick(); tick();
    out_ready = 1'b0;

    // Simultaneous push and pop at level 2
    offer_i(16'h00A0);
    offer_i(16'h00B0);
    out_ready = 1'b1;
    offer_i(16'h00C0);
    chk("pp_level", 32'(level), 32'd2);
    chk("pp_word", instruction, 32'h200000B0);
    tick();
    chk("pp_word2", instruction, 32'h200000C0);
    tick();
    out_ready = 1'b0;

    // Flush with a tuple offered in the restart cycle
    for (int i = 0; i < 3; i++) offer_i(16'h0100 + 16'(i));
    restart = 1'b1;
    offer_i(16'h0DDD);
    restart = 1'b0;
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_pc", p_count, BASE);
    chk("fl_valid", 32'(out_valid), 32'd0);
    tick();
    chk("fl_absent", 32'(level), 32'd0);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) offer_i(16'h0200 + 16'(i));
    out_ready = 1'b1;
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_instr", instruction, 32'h0);
    chk("ar_pc", p_count, BASE);
    chk("ar_ready", 32'(in_ready), 32'd1);
    #8 reset_n = 1'b1;
    offer_i(16'h0300);
    chk("ar_after", instruction, 32'h20000300);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
